// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM state encoding,
// a clog2 helper and the chunk-count / counter-width derivations.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A single-chunk adder still needs a 1-bit counter to keep the port legal.
   function automatic int cnt_width(input int n_chunks);
      return (n_chunks <= 1) ? 1 : clog2(n_chunks);
   endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Operand/result handshake bundle for chunked_serial_adder.
// zero/ovf exist only when ADDER_FLAGS_EN is defined.
interface chunked_serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
`ifdef ADDER_FLAGS_EN
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, a, b, c_in, out_ready,
      input  in_ready, out_valid, sum, c_out, zero, ovf
   );
   modport slave (
      input  in_valid, a, b, c_in, out_ready,
      output in_ready, out_valid, sum, c_out, zero, ovf
   );
`else
   modport master (
      output in_valid, a, b, c_in, out_ready,
      input  in_ready, out_valid, sum, c_out
   );
   modport slave (
      input  in_valid, a, b, c_in, out_ready,
      output in_ready, out_valid, sum, c_out
   );
`endif
endinterface

// File: rtl/chunked_serial_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells;
// one instance is reused every cycle by chunked_serial_adder.
module chunk_adder #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   always_comb begin
      logic c;
      c = cin;
      s = '0;
      for (int i = 0; i < CHUNK; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder (a + b + c_in), CHUNK bits per clock, valid/ready on both sides.
// Define ADDER_FLAGS_EN to add the registered zero and signed-overflow flags.
module chunked_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   chunked_serial_adder_if.slave bus
);

   localparam int               NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int               CNT_W  = cnt_width(NCHUNK);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(NCHUNK - 1);

   state_t             state, state_nx;
   logic [WIDTH-1:0]   a_sh, b_sh, sum_r, sum_nx;
   logic               carry, c_out_r;
   logic [CNT_W-1:0]   cnt;
   logic [CHUNK-1:0]   chunk_s;
   logic               chunk_c;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_sh[CHUNK-1:0]),
      .b    (b_sh[CHUNK-1:0]),
      .cin  (carry),
      .s    (chunk_s),
      .cout (chunk_c)
   );

   // Each new chunk enters at the MSB end so after NCHUNK steps the LSB chunk sits at bit 0.
   if (CHUNK == WIDTH) begin : g_full
      assign sum_nx = chunk_s;
   end else begin : g_shift
      assign sum_nx = {chunk_s, sum_r[WIDTH-1:CHUNK]};
   end

   always_comb begin
      // NOTE: default assigned first so every path drives state_nx; otherwise a latch is inferred.
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.in_valid)  state_nx = RUN;
         RUN:     if (cnt == LAST)   state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_r   <= '0;
         carry   <= 1'b0;
         c_out_r <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a_sh  <= bus.a;
               b_sh  <= bus.b;
               carry <= bus.c_in;
               cnt   <= '0;
            end
            RUN: begin
               a_sh  <= a_sh >> CHUNK;
               b_sh  <= b_sh >> CHUNK;
               sum_r <= sum_nx;
               carry <= chunk_c;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) c_out_r <= chunk_c;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.sum       = sum_r;
   assign bus.c_out     = c_out_r;

`ifdef ADDER_FLAGS_EN
   // Operand MSBs are captured at accept because the shift registers lose them during RUN.
   logic a_msb, b_msb, zero_r, ovf_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         zero_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         a_msb <= bus.a[WIDTH-1];
         b_msb <= bus.b[WIDTH-1];
      end else if (state == RUN && cnt == LAST) begin
         zero_r <= (sum_nx == '0);
         ovf_r  <= (a_msb == b_msb) && (sum_nx[WIDTH-1] != a_msb);
      end
   end

   assign bus.zero = zero_r;
   assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder (WIDTH=8, CHUNK=2) plus a CHUNK sweep
// over 1/2/4/8; flag checks are compiled in when ADDER_FLAGS_EN is defined.
module tb_chunked_serial_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   chunked_serial_adder_if #(.WIDTH(8)) m_if ();

   chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m_if.slave)
   );

   // Sweep instances share one stimulus source; each reports its own result.
   logic       sw_valid;
   logic [7:0] sw_a, sw_b;
   logic       sw_cin;
   logic [3:0] sw_ov, sw_co;
   logic [7:0] sw_sum [4];

   for (genvar k = 0; k < 4; k++) begin : g_sw
      chunked_serial_adder_if #(.WIDTH(8)) s_if ();
      assign s_if.in_valid  = sw_valid;
      assign s_if.a         = sw_a;
      assign s_if.b         = sw_b;
      assign s_if.c_in      = sw_cin;
      assign s_if.out_ready = 1'b1;
      chunked_serial_adder #(.WIDTH(8), .CHUNK(1 << k)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (s_if.slave)
      );
      assign sw_ov[k]  = s_if.out_valid;
      assign sw_co[k]  = s_if.c_out;
      assign sw_sum[k] = s_if.sum;
   end

   // Starts at a negedge in IDLE; returns at the negedge where out_valid is first seen (or timeout).
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output int lat, output bit ir_bad);
      ir_bad = 1'b0;
      lat    = -1;
      m_if.a = a; m_if.b = b; m_if.c_in = cin; m_if.in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      m_if.in_valid = 1'b0; m_if.a = ~a; m_if.b = 8'h5A; m_if.c_in = ~cin;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (m_if.in_ready) ir_bad = 1'b1;
         @(posedge clk); @(negedge clk);
         if (m_if.out_valid) begin
            lat = cyc;
            break;
         end
      end
   endtask

   task automatic test_vector(input logic [7:0] a, input logic [7:0] b, input logic cin,
                              input logic [7:0] exp_sum, input logic exp_cout,
                              input logic exp_zero, input logic exp_ovf);
      int lat;
      bit ir_bad;
      run_txn(a, b, cin, lat, ir_bad);
      n_tests++;
      if (lat !== 4) begin
         n_fail++; $display("FAIL latency %0d+%0d: got %0d cycles, expected 4", a, b, lat);
      end
      n_tests++;
      if (m_if.sum !== exp_sum || m_if.c_out !== exp_cout) begin
         n_fail++;
         $display("FAIL sum %0d+%0d+%0d: got sum=%0d c_out=%b, expected sum=%0d c_out=%b",
                  a, b, cin, m_if.sum, m_if.c_out, exp_sum, exp_cout);
      end
      n_tests++;
      if (ir_bad !== 1'b0) begin
         n_fail++; $display("FAIL busy_in_ready %0d+%0d: in_ready seen high during RUN", a, b);
      end
`ifdef ADDER_FLAGS_EN
      n_tests++;
      if (m_if.zero !== exp_zero || m_if.ovf !== exp_ovf) begin
         n_fail++;
         $display("FAIL flags %0d+%0d+%0d: got zero=%b ovf=%b, expected zero=%b ovf=%b",
                  a, b, cin, m_if.zero, m_if.ovf, exp_zero, exp_ovf);
      end
`else
      if (exp_zero === 1'bx || exp_ovf === 1'bx) $display("note: flag expectation undefined");
`endif
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL release %0d+%0d: got in_ready=%b out_valid=%b, expected 1/0",
                  a, b, m_if.in_ready, m_if.out_valid);
      end
   endtask

   task automatic test_reset;
      m_if.in_valid = 1'b0; m_if.a = 8'hFF; m_if.b = 8'hFF; m_if.c_in = 1'b1;
      m_if.out_ready = 1'b1;
      sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0;
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      n_tests++;
      if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0 ||
          m_if.sum !== 8'd0 || m_if.c_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got in_ready=%b out_valid=%b sum=%0d c_out=%b, expected 1/0/0/0",
                  m_if.in_ready, m_if.out_valid, m_if.sum, m_if.c_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_arith;
      test_vector(8'd22,  8'd33,  1'b0, 8'd55,  1'b0, 1'b0, 1'b0);
      test_vector(8'd128, 8'd128, 1'b1, 8'd1,   1'b1, 1'b0, 1'b1);
      test_vector(8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b1, 1'b0);
      test_vector(8'd100, 8'd100, 1'b0, 8'd200, 1'b0, 1'b0, 1'b1);
      test_vector(8'd91,  8'd11,  1'b1, 8'd103, 1'b0, 1'b0, 1'b0);
      test_vector(8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
      test_vector(8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure;
      int  lat;
      bit  ir_bad;
      bit  stable;
      m_if.out_ready = 1'b0;
      run_txn(8'd200, 8'd100, 1'b0, lat, ir_bad);
      // Offer the next operands while the result is stalled; they must wait for the handshake.
      m_if.a = 8'd1; m_if.b = 8'd1; m_if.c_in = 1'b0; m_if.in_valid = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (m_if.out_valid !== 1'b1 || m_if.in_ready !== 1'b0 ||
             m_if.sum !== 8'd44 || m_if.c_out !== 1'b1) stable = 1'b0;
         @(posedge clk); @(negedge clk);
      end
      n_tests++;
      if (lat !== 4 || stable !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_hold: got lat=%0d stable=%b sum=%0d c_out=%b, expected 4/1/44/1",
                  lat, stable, m_if.sum, m_if.c_out);
      end
      m_if.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (m_if.in_ready !== 1'b1 || m_if.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release: got in_ready=%b out_valid=%b, expected 1/0",
                  m_if.in_ready, m_if.out_valid);
      end
      @(posedge clk); @(negedge clk);
      m_if.in_valid = 1'b0;
      n_tests++;
      if (m_if.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL next_accept: got in_ready=%b, expected 0", m_if.in_ready);
      end
      lat = -1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk); @(negedge clk);
         if (m_if.out_valid) begin
            lat = cyc;
            break;
         end
      end
      n_tests++;
      if (lat !== 4 || m_if.sum !== 8'd2 || m_if.c_out !== 1'b0) begin
         n_fail++;
         $display("FAIL next_result: got lat=%0d sum=%0d c_out=%b, expected 4/2/0",
                  lat, m_if.sum, m_if.c_out);
      end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      bit rose;
      m_if.a = 8'd22; m_if.b = 8'd33; m_if.c_in = 1'b0; m_if.in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      m_if.in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1 ||
          m_if.sum !== 8'd0 || m_if.c_out !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_reset: got out_valid=%b in_ready=%b sum=%0d c_out=%b, expected 0/1/0/0",
                  m_if.out_valid, m_if.in_ready, m_if.sum, m_if.c_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      rose = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); @(negedge clk);
         if (m_if.out_valid || !m_if.in_ready) rose = 1'b1;
      end
      n_tests++;
      if (rose !== 1'b0) begin
         n_fail++; $display("FAIL abort_quiet: got activity after abort, expected idle");
      end
      test_vector(8'd34, 8'd78, 1'b1, 8'd113, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_sweep;
      logic [8:0] exp_v;
      bit   [3:0] done;
      for (int v = 0; v < 1000; v++) begin
         sw_a = 8'($urandom); sw_b = 8'($urandom); sw_cin = 1'($urandom);
         exp_v = {1'b0, sw_a} + {1'b0, sw_b} + {8'd0, sw_cin};
         sw_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         sw_valid = 1'b0; sw_a = ~sw_a; sw_b = ~sw_b;
         done = '0;
         for (int cyc = 1; cyc <= 12 && done != 4'hF; cyc++) begin
            @(posedge clk); @(negedge clk);
            for (int k = 0; k < 4; k++) begin
               if (!done[k] && sw_ov[k]) begin
                  done[k] = 1'b1;
                  n_tests++;
                  if ({sw_co[k], sw_sum[k]} !== exp_v || cyc != (8 >> k)) begin
                     n_fail++;
                     $display("FAIL sweep_chunk%0d vec %0d: got %0d after %0d cycles, expected %0d after %0d",
                              1 << k, v, {sw_co[k], sw_sum[k]}, cyc, exp_v, 8 >> k);
                  end
               end
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (!done[k]) begin
               n_tests++; n_fail++;
               $display("FAIL sweep_timeout_chunk%0d vec %0d: got no out_valid, expected one", 1 << k, v);
            end
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_reset_mid_run();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
